vend_rx_ctrl: RTL
=================

VEND_RX_CTRL -- requirements
Module: vend_rx_ctrl

Interface
REQ-001 SHALL have parameter DISPENSE_CYCLES, default 100_000_000, dispense level hold time in clk cycles.
REQ-002 SHALL have parameter CHANGE_CYCLES, default 50_000_000, change level hold time in clk cycles.
REQ-003 SHALL have parameters PRICE_A, PRICE_B, PRICE_C, defaults 25, 50, 75, product prices in cents.
REQ-004 SHALL have parameter CREDIT_MAX, default 200, credit ceiling in cents.
REQ-005 SHALL have ports in this order:
- clk  input  1  single system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- rx_valid  input  1  one-cycle pulse, rx_data holds a received UART byte.
- rx_data  input  8  received ASCII byte.
- credit  output  8  current credit in cents.
- dispense  output  3  one-hot dispense level; bit0=A, bit1=B, bit2=C.
- change_out  output  1  change-return level.
- change_amt  output  8  amount being returned, valid while change_out=1.
- coin_reject  output  1  one-cycle pulse, coin refused.
- deny  output  1  one-cycle pulse, selection refused for insufficient credit.
- drop  output  1  one-cycle pulse, byte discarded because busy.
- busy  output  1  high in any state other than IDLE.

Function
REQ-006 SHALL implement an FSM with states IDLE, DISPENSE, CHANGE.
REQ-007 SHALL decode bytes only in IDLE on a cycle with rx_valid=1; all effects SHALL be visible on the next rising edge (1-cycle latency).
REQ-008 SHALL decode 'n'(0x6E)=+5, 'd'(0x64)=+10, 'q'(0x71)=+25, 'a'(0x61)/'b'(0x62)/'c'(0x63)=select A/B/C, 'r'(0x72)=refund; any other byte SHALL be ignored with no pulse.
REQ-009 On a coin, if credit+value <= CREDIT_MAX, credit SHALL increase by value; otherwise credit SHALL be unchanged and coin_reject SHALL pulse; the sum SHALL be computed 9 bits wide.
REQ-010 On a select with credit >= price: credit <= credit-price, the matching dispense bit <= 1, state <= DISPENSE, hold counter cleared.
REQ-011 On a select with credit < price: credit unchanged, deny SHALL pulse, state stays IDLE.
REQ-012 In DISPENSE, dispense SHALL stay high for exactly DISPENSE_CYCLES cycles, then clear; the next state SHALL be CHANGE if credit > 0, else IDLE.
REQ-013 Entering CHANGE (after dispense or on 'r'): change_amt <= credit, credit <= 0, change_out <= 1 in the same edge.
REQ-014 In CHANGE, change_out SHALL stay high for exactly CHANGE_CYCLES cycles, then clear together with change_amt <= 0, returning to IDLE.
REQ-015 'r' with credit = 0 SHALL be a no-op with no pulse.
REQ-016 rx_valid=1 while busy=1 SHALL discard the byte, pulse drop, and leave state, credit and counters unchanged.
REQ-017 The hold counter SHALL be 32 bits wide, clear on every state entry, and never wrap within a hold.
REQ-018 coin_reject, deny and drop SHALL each be high for exactly one cycle per event and never simultaneously.
REQ-019 The block SHALL contain no byte buffering; at most one byte is acted on per rx_valid pulse.

Reset
REQ-020 While reset_n=0, all outputs SHALL be 0 and state SHALL be IDLE, independent of clk.
REQ-021 Reset asserted mid-DISPENSE or mid-CHANGE SHALL abort the operation immediately, losing credit and clearing dispense/change_out without completing hold time.
REQ-022 After reset_n rises, the first rx_valid on a rising edge SHALL be decoded normally.

Verification (DISPENSE_CYCLES=4, CHANGE_CYCLES=3)
REQ-023 Bytes 'q','q','q' then 'c' -> credit 25,50,75; dispense=3'b100 for 4 cycles; then IDLE, credit 0, change_out never high.
REQ-024 'q','q','q','q' then 'b' -> credit 100, then 50 with dispense=3'b010 for 4 cycles, then change_out=1, change_amt=50, credit=0 for 3 cycles, then IDLE.
REQ-025 'd' then 'a' -> credit 10, deny pulses once, credit stays 10, dispense stays 0.
REQ-026 Eight 'q' then 'n' -> credit saturates at 200; 9th coin pulses coin_reject, credit stays 200.
REQ-027 'q','a' then 'q' during DISPENSE -> drop pulses once, credit 0 after dispense, no CHANGE entry.
REQ-028 'q','q','b', reset_n=0 on 2nd DISPENSE cycle -> all outputs 0 immediately; after release, 'r' is a no-op.

Source files
------------

// File: rtl/vend_rx_ctrl.sv
// vend_rx_ctrl: UART-byte driven vending controller (coins, selection, dispense and change hold timing)
// Ports: clk/reset_n (async active-low), rx_valid/rx_data byte strobe in;
// credit, dispense (one-hot A/B/C), change_out/change_amt levels,
// coin_reject/deny/drop one-cycle pulses, busy (state != IDLE) out.
module vend_rx_ctrl #(
  parameter int DISPENSE_CYCLES = 100_000_000,
  parameter int CHANGE_CYCLES   = 50_000_000,
  parameter int PRICE_A         = 25,
  parameter int PRICE_B         = 50,
  parameter int PRICE_C         = 75,
  parameter int CREDIT_MAX      = 200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] credit,
  output logic [2:0] dispense,
  output logic       change_out,
  output logic [7:0] change_amt,
  output logic       coin_reject,
  output logic       deny,
  output logic       drop,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;
  localparam logic [31:0] D_LAST = 32'(DISPENSE_CYCLES - 1);
  localparam logic [31:0] C_LAST = 32'(CHANGE_CYCLES - 1);
  localparam logic [8:0]  C_MAX  = 9'(CREDIT_MAX);
  localparam logic [7:0]  P_A    = 8'(PRICE_A);
  localparam logic [7:0]  P_B    = 8'(PRICE_B);
  localparam logic [7:0]  P_C    = 8'(PRICE_C);
  state_t      r_state, w_next;
  logic [7:0]  r_credit, w_credit, r_amt, w_amt;
  logic [2:0]  r_disp, w_disp;
  logic        r_chg, w_chg, r_rej, w_rej, r_deny, w_deny, r_drop, w_drop;
  logic [31:0] r_cnt, w_cnt;
  logic [7:0]  w_coin, w_price;
  logic [2:0]  w_sel;
  logic [8:0]  w_sum;
  logic        w_refund, w_enter_chg;
  assign w_coin   = (rx_data == 8'h6E) ? 8'd5 : (rx_data == 8'h64) ? 8'd10 : (rx_data == 8'h71) ? 8'd25 : 8'd0;
  assign w_sel    = {rx_data == 8'h63, rx_data == 8'h62, rx_data == 8'h61};
  assign w_price  = w_sel[0] ? P_A : w_sel[1] ? P_B : P_C;
  assign w_refund = rx_data == 8'h72;
  // 9-bit sum so an overflow past 255 still compares correctly against the ceiling
  assign w_sum    = {1'b0, r_credit} + {1'b0, w_coin};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next      = r_state;
    w_credit    = r_credit;
    w_disp      = r_disp;
    w_chg       = r_chg;
    w_amt       = r_amt;
    w_cnt       = r_cnt + 32'd1;
    w_rej       = 1'b0;
    w_deny      = 1'b0;
    w_drop      = 1'b0;
    w_enter_chg = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (rx_valid) begin
          if (w_coin != 8'd0) begin
            if (w_sum <= C_MAX) w_credit = w_sum[7:0];
            else                w_rej    = 1'b1;
          end else if (|w_sel) begin
            if (r_credit >= w_price) begin
              w_credit = r_credit - w_price;
              w_disp   = w_sel;
              w_next   = DISPENSE;
            end else w_deny = 1'b1;
          end else if (w_refund) w_enter_chg = r_credit != 8'd0;
        end
      end
      DISPENSE: begin
        w_drop = rx_valid;
        if (r_cnt == D_LAST) begin
          w_disp      = '0;
          w_cnt       = '0;
          w_next      = IDLE;
          w_enter_chg = r_credit != 8'd0;
        end
      end
      CHANGE: begin
        w_drop = rx_valid;
        if (r_cnt == C_LAST) begin
          w_chg  = 1'b0;
          w_amt  = '0;
          w_cnt  = '0;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    // shared CHANGE entry: refund from IDLE or leftover credit after a dispense
    if (w_enter_chg) begin
      w_amt    = r_credit;
      w_credit = '0;
      w_chg    = 1'b1;
      w_cnt    = '0;
      w_next   = CHANGE;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_credit <= '0;
      r_disp   <= '0;
      r_chg    <= 1'b0;
      r_amt    <= '0;
      r_cnt    <= '0;
      r_rej    <= 1'b0;
      r_deny   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_credit <= w_credit;
      r_disp   <= w_disp;
      r_chg    <= w_chg;
      r_amt    <= w_amt;
      r_cnt    <= w_cnt;
      r_rej    <= w_rej;
      r_deny   <= w_deny;
      r_drop   <= w_drop;
    end
  always_comb begin
    credit      = r_credit;
    dispense    = r_disp;
    change_out  = r_chg;
    change_amt  = r_amt;
    coin_reject = r_rej;
    deny        = r_deny;
    drop        = r_drop;
    busy        = r_state != IDLE;
  end
endmodule
